m68k_bus_responder: RTL and testbench
=====================================

Name: m68k_bus_responder

Overview:
- Terminating side of the 68000 asynchronous bus cycle. The CPLD address decoder drives the chip selects; this block answers each cycle the CPU opens.
- Watches as_n, fc and addr[23:20] and returns dtack_n after a per-region wait-state count.
- Returns vpa_n for interrupt-acknowledge cycles (autovector).
- Returns berr_n for unmapped regions or for cycles stalled past a watchdog limit.
- Sits in the CPLD next to the chip-select decoder, clocked by cpu_clk.

Parameters:
- ROM_WS, 2, wait states inserted for region 0x0 (ROM).
- RAM_WS, 0, wait states inserted for regions 0xC and 0xE (RAM1/RAM2).
- TIMEOUT, 64, cycles from cycle start to forced BERR. Must exceed max(ROM_WS,RAM_WS)+2; checked at elaboration.
- SYNC_STAGES, 2, synchronizer depth for as_n and single_step.

Ports:
- cpu_clk  in  1  system clock (CPU clock).
- rst  in  1  synchronous active-high reset.
- as_n  in  1  CPU address strobe, async, active low.
- addr_hi  in  4  addr[23:20].
- fc  in  3  CPU function code.
- rw  in  1  CPU read/write. Not used for decision; reserved for visibility.
- single_step  in  1  async step pushbutton, active high. Used only under the macro.
- step_mode  in  1  single-step mode enable. Used only under the macro.
- dtack_n  out  1  data transfer acknowledge, active low.
- vpa_n  out  1  valid peripheral address (autovector), active low.
- berr_n  out  1  bus error, active low.

Behaviour:
- Reset: state IDLE; dtack_n=1, vpa_n=1, berr_n=1; counters 0; synchronizers preset to as_n=1, single_step=0. Reset during any state forces these values at the next edge, regardless of as_n.
- as_n passes through an SYNC_STAGES-deep synchronizer to give as_s. All decisions use as_s. All outputs are registered and are a function of state only.
- States:
  - IDLE: all outputs inactive.
  - WAIT: wait-state counter running.
  - ACK: dtack_n=0.
  - VPA: vpa_n=0.
  - ERR: berr_n=0.
  - STEP_HOLD: exists only under the macro.
- IDLE, as_s=0: addr_hi and fc are captured into a register (stable while AS is low). Next state chosen by the captured values:
  - fc=3'b111 (IACK) -> VPA.
  - addr_hi=0x0 -> WAIT, wait counter = ROM_WS.
  - addr_hi=0xC or 0xE -> WAIT, wait counter = RAM_WS.
  - any other region -> ERR.
- WAIT: wait counter decrements each cycle. At counter==0 -> ACK.
- Watchdog:
  - Clears on leaving IDLE and increments every cycle in WAIT.
  - At watchdog==TIMEOUT-1 -> ERR.
  - If the wait counter also expires in that same cycle, ERR wins.
- ACK, VPA, ERR: held until as_s=1, then -> IDLE. The output deasserts on that same edge.
- as_s=1 in WAIT (aborted cycle) -> IDLE with no response. This has priority over counter expiry and watchdog.
- Latency: number edges with the first edge sampling as_n=0 as edge 1, SYNC_STAGES=2.
  - Leave IDLE at edge 3.
  - dtack_n=0 after edge 4+WS.
  - vpa_n=0 and berr_n=0 (unmapped) after edge 3.
  - Release: dtack_n/vpa_n/berr_n high after edge 3, counting from the first edge sampling as_n=1.
- Back-to-back cycles: as_n low again while still in IDLE is treated as a fresh cycle. There is no minimum idle gap beyond the synchronizer.
- At most one of dtack_n, vpa_n, berr_n is low at any time.

Optional Feature:
- Macro: M68K_SINGLE_STEP_EN.
- Enabled:
  - single_step passes through its own synchronizer plus a rising-edge detector.
  - In WAIT with step_mode=1, counter expiry -> STEP_HOLD instead of ACK.
  - STEP_HOLD holds all outputs inactive and freezes the watchdog. A detected rising edge -> ACK; as_s=1 -> IDLE.
  - A step edge arriving outside STEP_HOLD is discarded.
- Disabled:
  - single_step and step_mode are ignored, no STEP_HOLD state exists, and behaviour matches step_mode=0.

Decomposition:
- Package m68k_bus_pkg holds:
  - State enum.
  - Region constants REGION_ROM=4'h0, REGION_RAM1=4'hC, REGION_RAM2=4'hE.
  - FC_IACK=3'b111.
- Sub-module m68k_sync: parameterised-depth synchronizer with a reset value parameter. Instantiated for as_n and, under the macro, for single_step.

Test Plan:
- ROM read: addr_hi=0x0, fc=3'b110, as_n low for 12 cycles -> dtack_n low after edge 6, high 3 edges after as_n rises. vpa_n and berr_n stay 1.
- RAM2 write: addr_hi=0xE, RAM_WS=0 -> dtack_n low after edge 4. Immediate back-to-back RAM1 cycle -> second dtack_n after edge 4 of the new cycle.
- Unmapped: addr_hi=0x5 -> berr_n low after edge 3, dtack_n never low. IACK: fc=3'b111 -> vpa_n low after edge 3.
- Watchdog: ROM_WS=100, TIMEOUT=64 is rejected at elaboration. With ROM_WS=10, TIMEOUT=8 (override check in bench) -> berr_n low, dtack_n never low. Abort: as_n high at edge 4 with ROM_WS=2 -> no output asserts.
- Reset: rst=1 while dtack_n=0 -> all outputs 1 next edge, state IDLE even though as_n is still low. After rst drops, as_n still low starts a new cycle.
- M68K_SINGLE_STEP_EN with step_mode=1, RAM cycle, held 200 cycles -> no berr_n, no dtack_n. Pulse single_step -> dtack_n low within SYNC_STAGES+2 edges.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared state encoding, address-map constants and decode helper for the 68000 bus responder.
// STEP_HOLD exists only when M68K_SINGLE_STEP_EN is defined.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    VPA,
    ERR
`ifdef M68K_SINGLE_STEP_EN
    , STEP_HOLD
`endif
  } bus_state_t;

  localparam logic [3:0] REGION_ROM  = 4'h0;
  localparam logic [3:0] REGION_RAM1 = 4'hC;
  localparam logic [3:0] REGION_RAM2 = 4'hE;
  localparam logic [2:0] FC_IACK     = 3'b111;

  function automatic logic is_ram(input logic [3:0] region);
    return (region == REGION_RAM1) || (region == REGION_RAM2);
  endfunction

endpackage

// File: rtl/m68k_sync.sv
// Multi-flop synchronizer for asynchronous single-bit inputs; output takes RESET_VAL under reset.
module m68k_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/m68k_bus_responder.sv
// Terminates 68000 bus cycles with DTACK, VPA (autovector) or BERR after per-region wait states.
// Optional single-step hold of DTACK is enabled by defining M68K_SINGLE_STEP_EN.
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter int ROM_WS        = 2,
  parameter int RAM_WS        = 0,
  parameter int TIMEOUT       = 64,
  parameter int SYNC_STAGES   = 2,
  parameter bit TIMEOUT_CHECK = 1'b1
) (
  input  logic       cpu_clk,
  input  logic       rst,
  input  logic       as_n,
  input  logic [3:0] addr_hi,
  input  logic [2:0] fc,
  input  logic       rw,
  input  logic       single_step,
  input  logic       step_mode,
  output logic       dtack_n,
  output logic       vpa_n,
  output logic       berr_n
);

  localparam int MAX_WS = (ROM_WS > RAM_WS) ? ROM_WS : RAM_WS;
  localparam int WS_W   = (MAX_WS < 1) ? 1 : $clog2(MAX_WS + 1);
  localparam int WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  if (TIMEOUT_CHECK && (TIMEOUT <= MAX_WS + 2)) begin : g_timeout_check
    $error("m68k_bus_responder: TIMEOUT must exceed max(ROM_WS,RAM_WS)+2");
  end

  bus_state_t       state;
  logic [WS_W-1:0]  ws_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic [3:0]       cap_addr;
  logic [2:0]       cap_fc;
  logic             as_s;

  m68k_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_as_sync (
    .clk (cpu_clk),
    .rst (rst),
    .d   (as_n),
    .q   (as_s)
  );

`ifdef M68K_SINGLE_STEP_EN
  logic step_s;
  logic step_prev;
  logic step_rise;
  logic unused_inputs;

  m68k_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_step_sync (
    .clk (cpu_clk),
    .rst (rst),
    .d   (single_step),
    .q   (step_s)
  );

  always_ff @(posedge cpu_clk) begin
    if (rst) step_prev <= 1'b0;
    else     step_prev <= step_s;
  end

  assign step_rise     = step_s & ~step_prev;
  assign unused_inputs = rw;
`else
  logic unused_inputs;
  assign unused_inputs = ^{rw, single_step, step_mode};
`endif

  // Address and FC are stable for the whole AS-low window, so IDLE decodes the registered copy
  // taken one edge earlier; this also keeps the async bus lines off the decode path.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state    <= IDLE;
      ws_cnt   <= '0;
      wd_cnt   <= '0;
      cap_addr <= '0;
      cap_fc   <= '0;
      dtack_n  <= 1'b1;
      vpa_n    <= 1'b1;
      berr_n   <= 1'b1;
    end else begin
      cap_addr <= addr_hi;
      cap_fc   <= fc;
      case (state)
        IDLE: begin
          if (!as_s) begin
            wd_cnt <= '0;
            if (cap_fc == FC_IACK) begin
              state <= VPA;
              vpa_n <= 1'b0;
            end else if (cap_addr == REGION_ROM) begin
              state  <= WAIT;
              ws_cnt <= WS_W'(ROM_WS);
            end else if (is_ram(cap_addr)) begin
              state  <= WAIT;
              ws_cnt <= WS_W'(RAM_WS);
            end else begin
              state  <= ERR;
              berr_n <= 1'b0;
            end
          end
        end

        // Abort beats the watchdog, which beats wait-state expiry.
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (as_s) begin
            state <= IDLE;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            state  <= ERR;
            berr_n <= 1'b0;
          end else if (ws_cnt == '0) begin
`ifdef M68K_SINGLE_STEP_EN
            if (step_mode) begin
              state <= STEP_HOLD;
            end else begin
              state   <= ACK;
              dtack_n <= 1'b0;
            end
`else
            state   <= ACK;
            dtack_n <= 1'b0;
`endif
          end else begin
            ws_cnt <= ws_cnt - 1'b1;
          end
        end

`ifdef M68K_SINGLE_STEP_EN
        STEP_HOLD: begin
          if (as_s) begin
            state <= IDLE;
          end else if (step_rise) begin
            state   <= ACK;
            dtack_n <= 1'b0;
          end
        end
`endif

        ACK, VPA, ERR: begin
          if (as_s) begin
            state   <= IDLE;
            dtack_n <= 1'b1;
            vpa_n   <= 1'b1;
            berr_n  <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          dtack_n <= 1'b1;
          vpa_n   <= 1'b1;
          berr_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Scoreboard bench for m68k_bus_responder: a default instance and a short-watchdog instance share
// one monitor; only one instance runs a bus cycle at a time.
module tb_m68k_bus_responder;

  localparam int K_DTACK = 4;
  localparam int K_VPA   = 2;
  localparam int K_BERR  = 1;

  logic       cpu_clk = 1'b0;
  logic       rst = 1'b1;
  logic       as_n0 = 1'b1;
  logic       as_n1 = 1'b1;
  logic [3:0] addr_hi = '0;
  logic [2:0] fc = '0;
  logic       rw = 1'b1;
  logic       single_step = 1'b0;
  logic       step_mode = 1'b0;
  logic       dtack_n0, vpa_n0, berr_n0;
  logic       dtack_n1, vpa_n1, berr_n1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int assert_lo;
    int assert_hi;
    int release_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   mon_active = 1'b0;
  int   low;

  m68k_bus_responder u_dut0 (
    .cpu_clk     (cpu_clk),
    .rst         (rst),
    .as_n        (as_n0),
    .addr_hi     (addr_hi),
    .fc          (fc),
    .rw          (rw),
    .single_step (single_step),
    .step_mode   (step_mode),
    .dtack_n     (dtack_n0),
    .vpa_n       (vpa_n0),
    .berr_n      (berr_n0)
  );

  m68k_bus_responder #(
    .ROM_WS(10), .RAM_WS(0), .TIMEOUT(8), .SYNC_STAGES(2), .TIMEOUT_CHECK(1'b0)
  ) u_dut1 (
    .cpu_clk     (cpu_clk),
    .rst         (rst),
    .as_n        (as_n1),
    .addr_hi     (addr_hi),
    .fc          (fc),
    .rw          (rw),
    .single_step (single_step),
    .step_mode   (step_mode),
    .dtack_n     (dtack_n1),
    .vpa_n       (vpa_n1),
    .berr_n      (berr_n1)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    tests++;
    if (actual < lo || actual > hi) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Reference: which response a cycle gets and how many edges after AS falls it appears.
  function automatic void model(input logic [3:0] a, input logic [2:0] f, input int rom_ws,
                                input int ram_ws, input int tmo, output int kind, output int lat);
    int ws;
    ws = -1;
    if (f == 3'b111) begin
      kind = K_VPA; lat = 3;
    end else if (a == 4'h0) begin
      ws = rom_ws;
    end else if (a == 4'hC || a == 4'hE) begin
      ws = ram_ws;
    end else begin
      kind = K_BERR; lat = 3;
    end
    if (ws >= 0) begin
      if (ws >= tmo - 1) begin
        kind = K_BERR; lat = tmo + 3;
      end else begin
        kind = K_DTACK; lat = 4 + ws;
      end
    end
  endfunction

  // One bus cycle on instance sel: AS low for h edges, then high for g edges. Called at a negedge.
  task automatic applyStimulus(input int sel, input logic [3:0] a, input logic [2:0] f,
                               input int h, input int g);
    int   kind, lat, start;
    exp_t e;
    addr_hi = a;
    fc      = f;
    rw      = 1'($urandom);
`ifndef M68K_SINGLE_STEP_EN
    step_mode   = 1'($urandom);
    single_step = 1'($urandom);
`endif
    if (sel == 1) begin
      as_n1 = 1'b0;
      model(a, f, 10, 0, 8, kind, lat);
    end else begin
      as_n0 = 1'b0;
      model(a, f, 2, 0, 64, kind, lat);
    end
    start = cyc;
    if (lat <= h + 2) begin
      e.kind = kind; e.assert_lo = start + lat; e.assert_hi = start + lat;
      e.release_cyc = start + h + 3;
      exp_q.push_back(e);
    end
    repeat (h) @(negedge cpu_clk);
    as_n0 = 1'b1;
    as_n1 = 1'b1;
    repeat (g) @(negedge cpu_clk);
  endtask

  always @(negedge cpu_clk) begin
    low = {29'd0, ~(dtack_n0 & dtack_n1), ~(vpa_n0 & vpa_n1), ~(berr_n0 & berr_n1)};
    if (!mon_active && low != 0) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_response", low, 0);
      end else begin
        cur = exp_q.pop_front();
        checkOutput("response_kind", low, cur.kind);
        checkRange("assert_edge", cyc, cur.assert_lo, cur.assert_hi);
        mon_active = 1'b1;
      end
    end else if (mon_active && low == 0) begin
      checkOutput("release_edge", cyc, cur.release_cyc);
      mon_active = 1'b0;
    end else if (mon_active && low != cur.kind) begin
      checkOutput("held_response", low, cur.kind);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int   start;
    int   h;
    exp_t e;
    logic [3:0] a;
    logic [2:0] f;

    repeat (3) @(negedge cpu_clk);
    checkOutput("reset_outputs", {dtack_n0, vpa_n0, berr_n0, dtack_n1, vpa_n1, berr_n1}, 6'b111111);
    rst = 1'b0;
    repeat (2) @(negedge cpu_clk);

    applyStimulus(0, 4'h0, 3'b110, 12, 4);
    applyStimulus(0, 4'hE, 3'b101, 6, 1);
    applyStimulus(0, 4'hC, 3'b101, 6, 3);
    applyStimulus(0, 4'h5, 3'b101, 6, 2);
    applyStimulus(0, 4'h3, 3'b111, 6, 2);
    applyStimulus(0, 4'h0, 3'b110, 3, 5);
    applyStimulus(1, 4'h0, 3'b110, 16, 3);
    applyStimulus(1, 4'hE, 3'b001, 5, 2);

    // Reset while DTACK is asserted, with AS held low across the reset.
    addr_hi = 4'h0; fc = 3'b110; as_n0 = 1'b0; start = cyc;
    e.kind = K_DTACK; e.assert_lo = start + 6; e.assert_hi = start + 6; e.release_cyc = start + 9;
    exp_q.push_back(e);
    repeat (8) @(negedge cpu_clk);
    rst = 1'b1;
    @(negedge cpu_clk);
    rst = 1'b0; start = cyc;
    e.kind = K_DTACK; e.assert_lo = start + 6; e.assert_hi = start + 6; e.release_cyc = start + 11;
    exp_q.push_back(e);
    repeat (8) @(negedge cpu_clk);
    as_n0 = 1'b1;
    repeat (4) @(negedge cpu_clk);

`ifdef M68K_SINGLE_STEP_EN
    // Held RAM cycle must wait indefinitely for the step button.
    step_mode = 1'b1; single_step = 1'b0;
    addr_hi = 4'hC; fc = 3'b101; as_n0 = 1'b0;
    repeat (200) @(negedge cpu_clk);
    single_step = 1'b1; start = cyc;
    e.kind = K_DTACK; e.assert_lo = start + 1; e.assert_hi = start + 4; e.release_cyc = start + 11;
    exp_q.push_back(e);
    repeat (4) @(negedge cpu_clk);
    single_step = 1'b0;
    repeat (4) @(negedge cpu_clk);
    as_n0 = 1'b1;
    repeat (5) @(negedge cpu_clk);
    step_mode = 1'b0;
`endif

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 4'h0;
        1:       a = 4'hC;
        2:       a = 4'hE;
        default: a = 4'($urandom);
      endcase
      f = ($urandom_range(0, 4) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      h = $urandom_range(1, 14);
      applyStimulus((i % 4 == 3) ? 1 : 0, a, f, h, $urandom_range(1, 4));
    end

    repeat (10) @(negedge cpu_clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("monitor_idle", int'(mon_active), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
